// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and its controller: sweep control, golden table, DUT hookup and results.
interface truth_table_checker_if #(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned TABLE_W = 1 << N_IN;

  logic                start;
  logic [TABLE_W-1:0]  expected;
  logic                y_in;
  logic [N_IN-1:0]     vec_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [TABLE_W-1:0]  table_out;
  logic [N_IN:0]       fail_count;
  logic [N_IN-1:0]     first_fail_idx;

  modport master (
    output start, expected, y_in,
    input  vec_out, busy, done, pass, table_out, fail_count, first_fail_idx
  );

  modport slave (
    input  start, expected, y_in,
    output vec_out, busy, done, pass, table_out, fail_count, first_fail_idx
  );
endinterface

// File: rtl/truth_table_checker.sv
// Self-test engine: sweeps every input vector of a small combinational block, captures Y after a settle
// interval and compares the captured truth table against a golden table.
module truth_table_checker #(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_checker_if.slave bus
);
  localparam int unsigned TABLE_W = 1 << N_IN;
  localparam int unsigned FC_W    = N_IN + 1;
  localparam int unsigned CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  state_e             state_q,   state_d;
  logic [N_IN-1:0]    vec_q,     vec_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [TABLE_W-1:0] table_q,   table_d;
  logic [TABLE_W-1:0] exp_q,     exp_d;
  logic [FC_W-1:0]    fail_q,    fail_d;
  logic [N_IN-1:0]    first_q,   first_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               pass_q,    pass_d;

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      fail_q  <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Sweep sequencing, capture and comparison
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    exp_d   = exp_q;
    fail_d  = fail_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          exp_d   = bus.expected;
          fail_d  = '0;
          first_d = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        table_d[vec_q] = bus.y_in;
        if (bus.y_in != exp_q[vec_q]) begin
          fail_d = fail_q + FC_W'(1);
          // Only the lowest failing vector is kept; the sweep runs in ascending order.
          if (fail_q == '0) begin
            first_d = vec_q;
          end
        end
        if (vec_q == N_IN'(TABLE_W - 1)) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (fail_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.table_out      = table_q;
  assign bus.fail_count     = fail_q;
  assign bus.first_fail_idx = first_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE_CYCLES 2 and 1) each driving a table-defined DUT.
module tb_truth_table_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(4)) bus0 ();
  truth_table_checker_if #(.N_IN(4)) bus1 ();

  truth_table_checker #(.N_IN(4), .SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  truth_table_checker #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Circuits under test: arbitrary truth functions; instance 0 also glitches Y right after each vector change
  logic [15:0] tbl0 = 16'h0000;
  logic [15:0] tbl1 = 16'h0000;
  logic [3:0]  vprev0 = 4'h0;
  always @(posedge clk) vprev0 <= bus0.vec_out;
  assign bus0.y_in = tbl0[bus0.vec_out] ^ (bus0.vec_out != vprev0);
  assign bus1.y_in = tbl1[bus1.vec_out];

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  vec;
    logic [15:0] tbl;
    logic [4:0]  fail;
    logic [3:0]  first;
  } obs_t;

  function automatic obs_t observe(input int which);
    obs_t o;
    if (which == 0) o = {bus0.busy, bus0.done, bus0.pass, bus0.vec_out, bus0.table_out, bus0.fail_count, bus0.first_fail_idx};
    else            o = {bus1.busy, bus1.done, bus1.pass, bus1.vec_out, bus1.table_out, bus1.fail_count, bus1.first_fail_idx};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) bus0.start = v; else bus1.start = v;
  endtask

  task automatic set_exp(input int which, input logic [15:0] v);
    if (which == 0) bus0.expected = v; else bus1.expected = v;
  endtask

  // One sweep with optional extra start pulses and an optional mid-sweep reset; results checked against a model
  task automatic sweep(input int which, input int sc, input logic [15:0] exp, input logic [15:0] tbl,
                       input int p1, input int p2, input int p3, input int rst_at, input string tag);
    obs_t o;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   exp_done = 16 * (sc + 1) + 1;
    int   exp_fail = $countones(tbl ^ exp);
    int   exp_first = 0;
    logic [15:0] diff = tbl ^ exp;
    for (int i = 15; i >= 0; i--) if (diff[i]) exp_first = i;

    @(negedge clk);
    if (which == 0) tbl0 = tbl; else tbl1 = tbl;
    set_exp(which, exp);
    set_start(which, 1'b1);
    @(posedge clk); #1;
    o = observe(which);
    chk({tag, "_start_clears"}, {o.busy, o.vec, o.tbl, o.fail, o.first, o.pass},
        {1'b1, 4'd0, 16'h0, 5'd0, 4'd0, 1'b0});

    for (int c = 1; c <= exp_done + 6; c++) begin
      @(negedge clk);
      set_start(which, (c == p1) || (c == p2) || (c == p3));
      if (c == 10) set_exp(which, 16'($urandom));
      rst = (c == rst_at);
      @(posedge clk); #1;
      o = observe(which);
      if (o.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 10) chk({tag, "_vec_c10"}, 32'(o.vec), 32'(10 / (sc + 1)));
      if (c == rst_at) chk({tag, "_rst_mid"}, {o.busy, o.done, o.vec, o.tbl, o.fail},
                           {1'b0, 1'b0, 4'd0, 16'h0, 5'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    set_start(which, 1'b0);
    o = observe(which);

    if (rst_at > 0) begin
      chk({tag, "_no_done"}, 32'(done_cnt), 32'd0);
      chk({tag, "_idle_busy"}, 32'(o.busy), 32'd0);
    end else begin
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
      chk({tag, "_busy_end"}, 32'(o.busy), 32'd0);
      chk({tag, "_vec_end"}, 32'(o.vec), 32'd15);
      chk({tag, "_table"}, 32'(o.tbl), 32'(tbl));
      chk({tag, "_fail"}, 32'(o.fail), 32'(exp_fail));
      chk({tag, "_first"}, 32'(o.first), 32'(exp_first));
      chk({tag, "_pass"}, 32'(o.pass), 32'(exp_fail == 0));
    end
  endtask

  initial begin
    obs_t o;
    logic [15:0] rt;
    logic [15:0] rm;
    bus0.start = 1'b0; bus0.expected = 16'h0;
    bus1.start = 1'b0; bus1.expected = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    o = observe(0);
    chk("reset0", 32'(o), 32'd0);
    o = observe(1);
    chk("reset1", 32'(o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    sweep(0, 2, 16'h6996, 16'h6996, 0, 0, 0, 0, "xor_pass");
    sweep(0, 2, 16'h9669, 16'h6996, 0, 0, 0, 0, "xor_allfail");
    sweep(0, 2, 16'h6B96, 16'h6996, 0, 0, 0, 0, "xor_bit9");
    sweep(0, 2, 16'h6996, 16'h6996, 5, 30, 49, 0, "start_ignored");
    sweep(0, 2, 16'h6996, 16'h6996, 0, 0, 0, 20, "rst_abort");
    sweep(0, 2, 16'h6B96, 16'h6996, 0, 0, 0, 0, "after_rst");
    sweep(1, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, "settle1_ones");

    for (int k = 0; k < 4; k++) begin
      rt = 16'($urandom);
      rm = 16'($urandom) & 16'($urandom) & 16'($urandom);
      sweep(0, 2, rt ^ rm, rt, 0, 0, 0, 0, "rand0");
    end
    rt = 16'($urandom);
    rm = 16'($urandom) & 16'($urandom);
    sweep(1, 1, rt ^ rm, rt, 0, 0, 0, 0, "rand1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
